// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the shared UART transmitter: byte handshakes in, serial line and status out.
// Handshake: requester i's byte transfers in the cycle where req_valid[i] & req_ready[i]; a requester holds valid and data until then.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                 baud_tick;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx;
    logic                 busy;
    logic [GW-1:0]        grant_id;
    logic [2:0]           fsm_state;

    modport master (
        output baud_tick, req_valid, req_data,
        input  req_ready, tx, busy, grant_id, fsm_state
    );

    modport slave (
        input  baud_tick, req_valid, req_data,
        output req_ready, tx, busy, grant_id, fsm_state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter; every transition is gated by baud_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit7 and the stop bit.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int DATA_BITS = 8;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   tx_q, tx_d;
    logic [GW-1:0]          last_q, last_d;
    logic [GW-1:0]          gid_q, gid_d;
    logic [NUM_REQ-1:0]     ready;
    logic [GW-1:0]          pick;

    // First valid requester at or after last+1, wrapping around.
    function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] last,
                                              input logic [NUM_REQ-1:0] valid);
        logic [GW-1:0] sel;
        logic [GW-1:0] cand;
        logic          found;
        int            idx;
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = GW'(idx);
            if (!found && valid[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(last_q, bus.req_valid);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        last_d  = last_q;
        gid_d   = gid_q;
        ready   = '0;
        if (bus.baud_tick) begin
            case (state_q)
                IDLE, STOP: begin
                    if (|bus.req_valid) begin
                        state_d     = START;
                        tx_d        = 1'b0;
                        data_d      = bus.req_data[{pick, 3'b000} +: DATA_BITS];
                        last_d      = pick;
                        gid_d       = pick;
                        ready[pick] = rst;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
                START: begin
                    state_d = DATA;
                    tx_d    = data_q[0];
                    cnt_d   = 3'd0;
                end
                DATA: begin
                    if (cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        tx_d  = data_q[cnt_q + 3'd1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
`endif
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    // Reset wins over everything, including a grant in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= 3'd0;
            tx_q    <= 1'b1;
            last_q  <= LAST_INIT;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx        = tx_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = gid_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: line-level frame model checked every cycle plus directed literal scenarios.
// Builds with or without UART_TX_PARITY_EN; the model and frame length follow the macro.
module tb_uart_tx_arbiter;
    localparam int N = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FT = 11;
`else
    localparam int FT = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
    uart_tx_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    bit hold_mode = 1'b0;
    bit rand_mode = 1'b0;
    logic [N-1:0] last_acc;
    logic [N-1:0] acc_or;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle with the given tick; requesters react to their ready afterwards.
    task automatic cyc(input logic t);
        logic [N-1:0] acc;
        bus.baud_tick = t;
        @(negedge clk);
        acc      = bus.req_ready & bus.req_valid;
        last_acc = bus.req_ready;
        acc_or   = acc_or | bus.req_ready;
        @(posedge clk);
        #1;
        bus.baud_tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && !hold_mode) begin
                bus.req_valid[i]      = 1'b0;
                bus.req_data[8*i +: 8] = 8'($urandom_range(0, 255));
            end
            if (rand_mode && !bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                bus.req_valid[i]      = 1'b1;
                bus.req_data[8*i +: 8] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // Model: the line is a queue of levels still to be sent in the current frame.
    logic [0:0] exp_q[$];
    logic       exp_tx = 1'b1;
    logic       exp_busy = 1'b0;
    int         exp_gid = 0;
    int         exp_last = N - 1;
    bit         model_live = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] want_rdy;
        logic [7:0]   b;
        int           sel;
        if (model_live) begin
            chk("tx", 32'(bus.tx), 32'(exp_tx));
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("grant_id", 32'(bus.grant_id), exp_gid);
        end
        want_rdy = '0;
        if (!rst) begin
            exp_q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            exp_gid  = 0;
            exp_last = N - 1;
        end else if (bus.baud_tick) begin
            if (exp_q.size() != 0) begin
                exp_tx = exp_q.pop_front();
            end else if (bus.req_valid != '0) begin
                sel = -1;
                for (int k = 1; k <= N; k++) begin
                    if (sel < 0 && bus.req_valid[(exp_last + k) % N]) sel = (exp_last + k) % N;
                end
                want_rdy[sel] = 1'b1;
                b = bus.req_data[8*sel +: 8];
                for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
`ifdef UART_TX_PARITY_EN
                exp_q.push_back(^b);
`endif
                exp_q.push_back(1'b1);
                exp_tx   = 1'b0;
                exp_busy = 1'b1;
                exp_gid  = sel;
                exp_last = sel;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end
        if (model_live) chk("req_ready", 32'(bus.req_ready), 32'(want_rdy));
        if (!rst) model_live = 1'b1;
    end

    logic [15:0] rec;
    logic [15:0] want;
    int          gc;
    int          g_tick[8];
    logic [N-1:0] g_rdy[8];
    int          g_id[8];

    initial begin
        rst           = 1'b0;
        bus.baud_tick = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        acc_or        = '0;
        cyc(0);
        cyc(0);
        chk("reset_tx", 32'(bus.tx), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_grant_id", 32'(bus.grant_id), 32'd0);
        chk("reset_ready", 32'(last_acc), 32'd0);
        chk("reset_state", 32'(bus.fsm_state), 32'd0);
        rst = 1'b1;
        cyc(0);

        // Single byte 0xA5 from requester 0, ticks spaced by idle cycles.
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid     = 2'b01;
        rec = '0;
        cyc(1);
        chk("a5_ready", 32'(last_acc), 32'h1);
        rec[0] = bus.tx;
        for (int t = 1; t < FT; t++) begin
            cyc(0);
            cyc(0);
            cyc(1);
            rec[t] = bus.tx;
        end
`ifdef UART_TX_PARITY_EN
        want = 16'b00000_10101001010;
`else
        want = 16'b000000_1101001010;
`endif
        chk("a5_frame", 32'(rec), 32'(want));
        chk("a5_busy_in_stop", 32'(bus.busy), 32'd1);
        cyc(1);
        chk("a5_busy_after", 32'(bus.busy), 32'd0);

        // Valid raised between ticks: nothing happens until a tick arrives.
        bus.req_data[15:8] = 8'h5A;
        bus.req_valid      = 2'b10;
        acc_or             = '0;
        repeat (4) cyc(0);
        chk("gate_no_ready", 32'(acc_or), 32'd0);
        chk("gate_tx_idle", 32'(bus.tx), 32'd1);
        cyc(1);
        chk("gate_ready", 32'(last_acc), 32'h2);
        repeat (FT) cyc(1);

        // Fairness with both requesters held valid and ticks on consecutive cycles.
        rst = 1'b0;
        cyc(0);
        rst       = 1'b1;
        hold_mode = 1'b1;
        bus.req_data  = {8'h22, 8'h11};
        bus.req_valid = 2'b11;
        gc = 0;
        for (int t = 0; t < 4 * FT; t++) begin
            cyc(1);
            if (last_acc != '0 && gc < 8) begin
                g_tick[gc] = t;
                g_rdy[gc]  = last_acc;
                g_id[gc]   = int'(bus.grant_id);
                gc++;
            end
        end
        bus.req_valid = '0;
        hold_mode     = 1'b0;
        cyc(1);
        chk("fair_count", gc, 4);
        for (int g = 0; g < 4; g++) begin
            chk("fair_ready", 32'(g_rdy[g]), (g % 2 == 0) ? 32'h1 : 32'h2);
            chk("fair_grant_id", g_id[g], g % 2);
            chk("fair_spacing", g_tick[g], g * FT);
        end

        // Reset during data bit3, with a tick and both requests present in the reset cycle.
        bus.req_data[7:0] = 8'h3C;
        bus.req_valid     = 2'b01;
        repeat (5) cyc(1);
        rst               = 1'b0;
        bus.req_data      = {8'h81, 8'h7E};
        bus.req_valid     = 2'b11;
        cyc(1);
        chk("rst_no_ready", 32'(last_acc), 32'd0);
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        rst = 1'b1;
        cyc(1);
        chk("rst_first_winner", 32'(last_acc), 32'h1);
        repeat (2 * FT + 1) cyc(1);
        chk("rst_drained", 32'(bus.busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity bit sits right after bit7.
        bus.req_data[7:0] = 8'h07;
        bus.req_valid     = 2'b01;
        for (int t = 0; t < FT; t++) begin
            cyc(1);
            rec[t] = bus.tx;
        end
        chk("parity_07", 32'(rec[9]), 32'd1);
        bus.req_data[7:0] = 8'h03;
        bus.req_valid     = 2'b01;
        cyc(1);
        for (int t = 1; t < FT; t++) begin
            cyc(1);
            rec[t] = bus.tx;
        end
        chk("parity_03", 32'(rec[9]), 32'd0);
        cyc(1);
`endif

        // Random requests over 1000 ticks with random spacing.
        rand_mode = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            cyc(1);
            repeat ($urandom_range(0, 2)) cyc(0);
        end
        rand_mode     = 1'b0;
        bus.req_valid = '0;
        repeat (FT + 2) cyc(1);
        chk("final_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
